// File: rtl/ram32m_fifo_pkg.sv
// rtl/ram32m_fifo_pkg.sv - shared sizes and output-stage state type for the RAM32M FIFO
package ram32m_fifo_pkg;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 6;
  localparam int PTR_W  = 5;
  localparam int CNT_W  = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/ram32m_fifo_ctrl_ram32m.sv
// rtl/ram32m_fifo_ctrl_ram32m.sv - behavioural RAM32M: 32x2 quad-port, write on D address, async reads
module RAM32M #(
  parameter logic [63:0] INIT_A           = 64'h0,
  parameter logic [63:0] INIT_B           = 64'h0,
  parameter logic [63:0] INIT_C           = 64'h0,
  parameter logic [63:0] INIT_D           = 64'h0,
  parameter logic [0:0]  IS_WCLK_INVERTED = 1'b0
) (
  output logic [1:0] DOA,
  output logic [1:0] DOB,
  output logic [1:0] DOC,
  output logic [1:0] DOD,
  input  logic [1:0] DIA,
  input  logic [1:0] DIB,
  input  logic [1:0] DIC,
  input  logic [1:0] DID,
  input  logic [4:0] ADDRA,
  input  logic [4:0] ADDRB,
  input  logic [4:0] ADDRC,
  input  logic [4:0] ADDRD,
  input  logic       WE,
  input  logic       WCLK
);

  // Arrays hold the difference from INIT, so power-up contents equal INIT without a reset.
  logic [63:0] mem_a;
  logic [63:0] mem_b;
  logic [63:0] mem_c;
  logic [63:0] mem_d;
  logic        wclk_int;

  assign wclk_int = WCLK ^ IS_WCLK_INVERTED[0];

  // All four columns share the D-port write address.
  always_ff @(posedge wclk_int) begin
    if (WE) begin
      mem_a[{ADDRD, 1'b0} +: 2] <= DIA ^ INIT_A[{ADDRD, 1'b0} +: 2];
      mem_b[{ADDRD, 1'b0} +: 2] <= DIB ^ INIT_B[{ADDRD, 1'b0} +: 2];
      mem_c[{ADDRD, 1'b0} +: 2] <= DIC ^ INIT_C[{ADDRD, 1'b0} +: 2];
      mem_d[{ADDRD, 1'b0} +: 2] <= DID ^ INIT_D[{ADDRD, 1'b0} +: 2];
    end
  end

  assign DOA = mem_a[{ADDRA, 1'b0} +: 2] ^ INIT_A[{ADDRA, 1'b0} +: 2];
  assign DOB = mem_b[{ADDRB, 1'b0} +: 2] ^ INIT_B[{ADDRB, 1'b0} +: 2];
  assign DOC = mem_c[{ADDRC, 1'b0} +: 2] ^ INIT_C[{ADDRC, 1'b0} +: 2];
  assign DOD = mem_d[{ADDRD, 1'b0} +: 2] ^ INIT_D[{ADDRD, 1'b0} +: 2];

endmodule

// File: rtl/ram32m_fifo_ctrl.sv
// rtl/ram32m_fifo_ctrl.sv - 32-entry RAM32M FIFO with registered output stage (33 words total)
module ram32m_fifo_ctrl
  import ram32m_fifo_pkg::*;
#(
  parameter int AFULL_LEVEL  = 30,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic [CNT_W-1:0]  COUNT,
  output logic              AFULL,
  output logic              AEMPTY
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] ram_cnt;
  out_state_t       state;
  out_state_t       state_next;
  logic             push;
  logic             load;
  logic             we;
  logic [1:0]       doa;
  logic [1:0]       dob;
  logic [1:0]       doc;
  logic [1:0]       dod_unused;

  // Ready depends on registered count only, so a load freeing a slot helps only next cycle.
  assign S_READY = (ram_cnt != CNT_W'(DEPTH));
  assign M_VALID = (state == ST_HOLD);
  assign push    = S_VALID && S_READY && !FLUSH;
  assign we      = push && !RST;
  // Load only from entries already written, so a flushed (stale) slot is never read out.
  assign load    = (ram_cnt != '0) && (!M_VALID || M_READY) && !FLUSH;

  assign COUNT   = ram_cnt + CNT_W'(M_VALID);
  assign AFULL   = (COUNT >= CNT_W'(AFULL_LEVEL));
  assign AEMPTY  = (COUNT <= CNT_W'(AEMPTY_LEVEL));

  RAM32M #(
    .INIT_A           (64'h0),
    .INIT_B           (64'h0),
    .INIT_C           (64'h0),
    .INIT_D           (64'h0),
    .IS_WCLK_INVERTED (1'b0)
  ) u_ram (
    .DOA   (doa),
    .DOB   (dob),
    .DOC   (doc),
    .DOD   (dod_unused),
    .DIA   (S_DATA[1:0]),
    .DIB   (S_DATA[3:2]),
    .DIC   (S_DATA[5:4]),
    .DID   (2'b00),
    .ADDRA (rd_ptr),
    .ADDRB (rd_ptr),
    .ADDRC (rd_ptr),
    .ADDRD (wr_ptr),
    .WE    (we),
    .WCLK  (CLK)
  );

  // Output-stage state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_EMPTY;
    else     state <= state_next;
  end

  // Output-stage next state: flush empties, a load fills, a take without refill empties.
  always_comb begin
    state_next = state;
    if (FLUSH)                     state_next = ST_EMPTY;
    else if (load)                 state_next = ST_HOLD;
    else if (M_VALID && M_READY)   state_next = ST_EMPTY;
  end

  // Pointers, RAM occupancy and the output data register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      M_DATA  <= '0;
    end else if (FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        M_DATA <= {doc, dob, doa};
      end
      ram_cnt <= ram_cnt + CNT_W'(push) - CNT_W'(load);
    end
  end

endmodule
